vga_object_renderer: RTL and testbench

//  Pixel-colour stage directly downstream of the 640x480@60Hz VGA timing controller.

---
 rtl/vga_object_renderer_if.sv | 25 ++
 rtl/vga_object_renderer.sv | 138 +++++++++++++
 tb/tb_vga_object_renderer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_object_renderer_if.sv
// Pixel-stream bundle between the VGA timing controller and the object renderer.
// The master drives coordinates, frame tick and player controls; the slave returns RGB.
interface vga_object_renderer_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       active;
    logic       frame_tick;
    logic [9:0] ship_x;
    logic [9:0] ship_y;
    logic       fire;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic [3:0] live_count;

    modport master (
        output pix_x, pix_y, active, frame_tick, ship_x, ship_y, fire,
        input  vga_r, vga_g, vga_b, live_count
    );

    modport slave (
        input  pix_x, pix_y, active, frame_tick, ship_x, ship_y, fire,
        output vga_r, vga_g, vga_b, live_count
    );
endinterface

// File: rtl/vga_object_renderer.sv
// Pixel-colour stage: holds the ship snapshot and a bullet pool, updated once per frame,
// and produces registered RGB one cycle after the pixel coordinates arrive.
module vga_object_renderer #(
    parameter int SHIP_SIZE    = 50,
    parameter int SHIP_X0      = 320,
    parameter int SHIP_Y0      = 240,
    parameter int NUM_BULLETS  = 4,
    parameter int BULLET_W     = 1,
    parameter int BULLET_H     = 5,
    parameter int BULLET_SPEED = 4,
    parameter int COOLDOWN     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_object_renderer_if.slave  vga
);

    localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int CD_W  = $clog2(COOLDOWN + 2);

    logic [9:0]             r_snap_x;
    logic [9:0]             r_snap_y;
    logic [NUM_BULLETS-1:0] r_live;
    logic [9:0]             r_bx [NUM_BULLETS];
    logic [9:0]             r_by [NUM_BULLETS];
    logic [CD_W-1:0]        r_cooldown;
    logic                   r_fire_pending;
    logic [3:0]             r_live_count;
    logic [7:0]             r_r;
    logic [7:0]             r_g;
    logic [7:0]             r_b;

    logic [NUM_BULLETS-1:0] w_live_moved;
    logic [NUM_BULLETS-1:0] w_live_next;
    logic [9:0]             w_by_moved [NUM_BULLETS];
    logic                   w_free_found;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_spawn;
    logic [3:0]             w_count_next;
    logic                   w_bullet_hit;
    logic                   w_ship_hit;
    logic [10:0]            w_px;
    logic [10:0]            w_py;

    // Frame update: move/free first, then the lowest free slot may take a new bullet.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_live_moved[i] = r_live[i] && (r_by[i] >= 10'(BULLET_SPEED));
            w_by_moved[i]   = r_by[i] - 10'(BULLET_SPEED);
        end
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!w_live_moved[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
        w_spawn = (r_fire_pending | vga.fire) && (r_cooldown == '0) && w_free_found &&
                  (vga.ship_y >= 10'(BULLET_H));
        w_live_next = w_live_moved;
        if (w_spawn) w_live_next[w_free_idx] = 1'b1;
        w_count_next = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_count_next = w_count_next + 4'(w_live_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_x       <= 10'(SHIP_X0);
            r_snap_y       <= 10'(SHIP_Y0);
            r_live         <= '0;
            r_cooldown     <= '0;
            r_fire_pending <= 1'b0;
            r_live_count   <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                r_bx[i] <= '0;
                r_by[i] <= '0;
            end
        end else begin
            if (vga.fire) r_fire_pending <= 1'b1;
            if (vga.frame_tick) begin
                r_snap_x <= vga.ship_x;
                r_snap_y <= vga.ship_y;
                r_live   <= w_live_next;
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    if (w_live_moved[i]) r_by[i] <= w_by_moved[i];
                end
                if (w_spawn) begin
                    r_bx[w_free_idx] <= vga.ship_x + 10'(SHIP_SIZE / 2);
                    r_by[w_free_idx] <= vga.ship_y - 10'(BULLET_H);
                    r_cooldown       <= CD_W'(COOLDOWN);
                end else if (r_cooldown != '0) begin
                    r_cooldown <= r_cooldown - 1'b1;
                end
                // Unserviceable requests are dropped rather than carried to the next frame.
                r_fire_pending <= 1'b0;
                r_live_count   <= w_count_next;
            end
        end
    end

    // Hit tests widen to 11 bits so objects near the right/bottom edge never wrap.
    always_comb begin
        w_px         = {1'b0, vga.pix_x};
        w_py         = {1'b0, vga.pix_y};
        w_bullet_hit = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (r_live[i] &&
                (w_px >= {1'b0, r_bx[i]}) && (w_px < ({1'b0, r_bx[i]} + 11'(BULLET_W))) &&
                (w_py >= {1'b0, r_by[i]}) && (w_py < ({1'b0, r_by[i]} + 11'(BULLET_H))))
                w_bullet_hit = 1'b1;
        end
        w_ship_hit = (w_px >= {1'b0, r_snap_x}) && (w_px < ({1'b0, r_snap_x} + 11'(SHIP_SIZE))) &&
                     (w_py >= {1'b0, r_snap_y}) && (w_py < ({1'b0, r_snap_y} + 11'(SHIP_SIZE)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_r, r_g, r_b} <= 24'h000000;
        end else if (!vga.active) begin
            {r_r, r_g, r_b} <= 24'h000000;
        end else if (w_bullet_hit) begin
            {r_r, r_g, r_b} <= 24'hFFFF00;
        end else if (w_ship_hit) begin
            {r_r, r_g, r_b} <= 24'h00FF00;
        end else begin
            {r_r, r_g, r_b} <= 24'h000020;
        end
    end

    assign vga.vga_r      = r_r;
    assign vga.vga_g      = r_g;
    assign vga.vga_b      = r_b;
    assign vga.live_count = r_live_count;

endmodule

// File: tb/tb_vga_object_renderer.sv
// Self-checking bench for vga_object_renderer: a per-frame reference model of the ship
// and bullet pool predicts RGB and live_count under directed and random stimulus.
module tb_vga_object_renderer;

    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    vga_object_renderer_if vif ();
    vga_object_renderer dut (.clk(clk), .rst(rst), .vga(vif.slave));

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];

    int m_live [4];
    int m_bx [4];
    int m_by [4];
    int m_cd;
    bit m_pend;
    int m_sx;
    int m_sy;

    function automatic logic [23:0] ref_color(input int x, input int y, input bit act);
        if (!act) return 24'h000000;
        for (int i = 0; i < 4; i++)
            if (m_live[i] != 0 && x >= m_bx[i] && x < m_bx[i] + 1 && y >= m_by[i] && y < m_by[i] + 5)
                return 24'hFFFF00;
        if (x >= m_sx && x < m_sx + 50 && y >= m_sy && y < m_sy + 50) return 24'h00FF00;
        return 24'h000020;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 4; i++) c += m_live[i];
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_live[i] = 0; m_bx[i] = 0; m_by[i] = 0;
        end
        m_cd = 0; m_pend = 0; m_sx = 320; m_sy = 240;
    endtask

    task automatic model_tick(input bit f);
        int free_i;
        m_sx = vif.ship_x;
        m_sy = vif.ship_y;
        for (int i = 0; i < 4; i++)
            if (m_live[i] != 0) begin
                if (m_by[i] < 4) m_live[i] = 0;
                else m_by[i] -= 4;
            end
        free_i = -1;
        for (int i = 0; i < 4; i++)
            if (m_live[i] == 0 && free_i < 0) free_i = i;
        if ((m_pend || f) && m_cd == 0 && free_i >= 0 && m_sy >= 5) begin
            m_live[free_i] = 1;
            m_bx[free_i] = m_sx + 25;
            m_by[free_i] = m_sy - 5;
            m_cd = 8;
        end else if (m_cd > 0) begin
            m_cd--;
        end
        m_pend = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        vif.pix_x = '0; vif.pix_y = '0; vif.active = 1'b0; vif.frame_tick = 1'b0;
        vif.ship_x = 10'd320; vif.ship_y = 10'd240; vif.fire = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_reset();
        step();
    endtask

    task automatic idle(input int n, input bit f);
        vif.fire = f;
        repeat (n) begin
            if (f) m_pend = 1;
            step();
        end
        vif.fire = 1'b0;
    endtask

    task automatic do_tick(input bit f);
        vif.active = 1'b0;
        vif.frame_tick = 1'b1;
        vif.fire = f;
        model_tick(f);
        step();
        vif.frame_tick = 1'b0;
        vif.fire = 1'b0;
    endtask

    task automatic drive_pix(input int x, input int y, input bit act, output logic [23:0] got);
        vif.pix_x = 10'(x);
        vif.pix_y = 10'(y);
        vif.active = act;
        step();
        got = {vif.vga_r, vif.vga_g, vif.vga_b};
        vif.active = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] got, exp;
        int px [6] = '{320, 0, 369, 370, 319, 320};
        int py [6] = '{240, 0, 289, 289, 240, 240};
        rst = 1'b1;
        vif.pix_x = 10'd320; vif.pix_y = 10'd240; vif.active = 1'b1; vif.frame_tick = 1'b0;
        vif.ship_x = 10'd320; vif.ship_y = 10'd240; vif.fire = 1'b0;
        step();
        n_checks++;
        if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 24'h0) begin
            n_fail++; $display("FAIL reset_rgb: got %h expected 000000", {vif.vga_r, vif.vga_g, vif.vga_b});
        end
        n_checks++;
        if (vif.live_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_live_count: got %0d expected 0", vif.live_count);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ref_color(px[i], py[i], i != 5));
            drive_pix(px[i], py[i], i != 5, got);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL reset_sweep(%0d,%0d): got %h expected %h", px[i], py[i], got, exp);
            end
        end
    endtask

    task automatic test_single_fire();
        logic [23:0] got, exp;
        int px [3] = '{345, 345, 346};
        int py [3] = '{237, 240, 237};
        apply_reset();
        vif.pix_x = 10'd100; vif.active = 1'b1;
        vif.fire = 1'b1; m_pend = 1; step(); vif.fire = 1'b0;
        idle(3, 1'b0);
        do_tick(1'b0);
        n_checks++;
        if (vif.live_count !== 4'd1) begin
            n_fail++; $display("FAIL single_fire_count: got %0d expected 1", vif.live_count);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ref_color(px[i], py[i], 1'b1));
            drive_pix(px[i], py[i], 1'b1, got);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp || (i == 0 && got !== 24'hFFFF00)) begin
                n_fail++; $display("FAIL single_fire_pix(%0d,%0d): got %h expected %h", px[i], py[i], got, exp);
            end
        end
    endtask

    task automatic test_cooldown();
        logic [23:0] got;
        apply_reset();
        for (int t = 1; t <= 10; t++) begin
            do_tick(1'b1);
            n_checks++;
            if (vif.live_count !== 4'(model_count())) begin
                n_fail++; $display("FAIL cooldown_count_tick%0d: got %0d expected %0d", t, vif.live_count, model_count());
            end
            if (t < 10) idle(2, 1'b1);
        end
        n_checks++;
        if (vif.live_count !== 4'd2) begin
            n_fail++; $display("FAIL cooldown_two_spawns: got %0d expected 2", vif.live_count);
        end
        drive_pix(345, 199, 1'b1, got);
        n_checks++;
        if (got !== 24'hFFFF00) begin
            n_fail++; $display("FAIL cooldown_first_bullet_y199: got %h expected FFFF00", got);
        end
        drive_pix(345, 198, 1'b1, got);
        n_checks++;
        if (got !== 24'h000020) begin
            n_fail++; $display("FAIL cooldown_above_bullet: got %h expected 000020", got);
        end
    endtask

    task automatic test_free_reuse();
        logic [23:0] got;
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            vif.ship_x = 10'd100; vif.ship_y = 10'd40;
            do_tick(1'b1);
            repeat (8) do_tick(1'b0);
            n_checks++;
            if (vif.live_count !== 4'd1) begin
                n_fail++; $display("FAIL reuse_setup_count: got %0d expected 1", vif.live_count);
            end
            do_tick(pass == 1);
            n_checks++;
            if (vif.live_count !== 4'(model_count()) || vif.live_count !== 4'(pass)) begin
                n_fail++; $display("FAIL reuse_free_count pass%0d: got %0d expected %0d", pass, vif.live_count, pass);
            end
            drive_pix(125, 35, 1'b1, got);
            n_checks++;
            if (got !== ref_color(125, 35, 1'b1)) begin
                n_fail++; $display("FAIL reuse_pix pass%0d: got %h expected %h", pass, got, ref_color(125, 35, 1'b1));
            end
        end
    endtask

    task automatic test_pool_full();
        apply_reset();
        vif.ship_x = 10'd300; vif.ship_y = 10'd200;
        for (int t = 1; t <= 37; t++) begin
            do_tick(1'b1);
            n_checks++;
            if (vif.live_count !== 4'(model_count())) begin
                n_fail++; $display("FAIL full_count_tick%0d: got %0d expected %0d", t, vif.live_count, model_count());
            end
            if (t < 37) idle(1, 1'b1);
        end
        n_checks++;
        if (vif.live_count !== 4'd4) begin
            n_fail++; $display("FAIL full_no_spawn: got %0d expected 4", vif.live_count);
        end
        for (int t = 38; t <= 55; t++) begin
            do_tick(1'b0);
            n_checks++;
            if (vif.live_count !== 4'(model_count())) begin
                n_fail++; $display("FAIL full_drain_tick%0d: got %0d expected %0d", t, vif.live_count, model_count());
            end
        end
        n_checks++;
        if (vif.live_count !== 4'd3) begin
            n_fail++; $display("FAIL full_pending_dropped: got %0d expected 3", vif.live_count);
        end
    endtask

    task automatic test_low_ship_and_reset();
        logic [23:0] got;
        apply_reset();
        vif.ship_y = 10'd3;
        do_tick(1'b1);
        n_checks++;
        if (vif.live_count !== 4'd0) begin
            n_fail++; $display("FAIL low_ship_no_spawn: got %0d expected 0", vif.live_count);
        end
        repeat (8) do_tick(1'b0);
        vif.ship_y = 10'd240;
        do_tick(1'b1);
        n_checks++;
        if (vif.live_count !== 4'd1) begin
            n_fail++; $display("FAIL low_ship_then_spawn: got %0d expected 1", vif.live_count);
        end
        vif.ship_x = 10'd0; vif.ship_y = 10'd0;
        drive_pix(330, 250, 1'b1, got);
        n_checks++;
        if (got !== 24'h00FF00) begin
            n_fail++; $display("FAIL pre_reset_pix: got %h expected 00FF00", got);
        end
        vif.active = 1'b1;
        #5 rst = 1'b1;
        #1;
        n_checks++;
        if ({vif.vga_r, vif.vga_g, vif.vga_b, vif.live_count} !== 28'h0) begin
            n_fail++; $display("FAIL async_reset_now: got %h/%0d expected 000000/0", {vif.vga_r, vif.vga_g, vif.vga_b}, vif.live_count);
        end
        step();
        n_checks++;
        if ({vif.vga_r, vif.vga_g, vif.vga_b, vif.live_count} !== 28'h0) begin
            n_fail++; $display("FAIL async_reset_edge: got %h/%0d expected 000000/0", {vif.vga_r, vif.vga_g, vif.vga_b}, vif.live_count);
        end
        rst = 1'b0;
        model_reset();
        drive_pix(320, 240, 1'b1, got);
        n_checks++;
        if (got !== 24'h00FF00) begin
            n_fail++; $display("FAIL post_reset_snapshot: got %h expected 00FF00", got);
        end
    endtask

    task automatic test_random();
        logic [23:0] got, exp;
        int x, y, s;
        bit act, f;
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            vif.ship_x = 10'($urandom_range(0, 589));
            vif.ship_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 8)) : 10'($urandom_range(0, 429));
            f = ($urandom_range(0, 2) == 0);
            idle($urandom_range(0, 2), $urandom_range(0, 3) == 0);
            do_tick(f);
            n_checks++;
            if (vif.live_count !== 4'(model_count())) begin
                n_fail++; $display("FAIL random_count_tick%0d: got %0d expected %0d", t, vif.live_count, model_count());
            end
            // Move the requested ship mid-frame; only the tick-time snapshot may be drawn.
            vif.ship_x = 10'($urandom_range(0, 589));
            vif.ship_y = 10'($urandom_range(0, 429));
            for (int k = 0; k < 12; k++) begin
                case ($urandom_range(0, 2))
                    0: begin
                        s = $urandom_range(0, 3);
                        x = m_bx[s] + $urandom_range(0, 2) - 1;
                        y = m_by[s] + $urandom_range(0, 6) - 1;
                    end
                    1: begin
                        x = m_sx + $urandom_range(0, 51) - 1;
                        y = m_sy + $urandom_range(0, 51) - 1;
                    end
                    default: begin
                        x = $urandom_range(0, 639);
                        y = $urandom_range(0, 479);
                    end
                endcase
                x = (x < 0) ? 0 : (x > 639) ? 639 : x;
                y = (y < 0) ? 0 : (y > 479) ? 479 : y;
                act = ($urandom_range(0, 7) != 0);
                exp_q.push_back(ref_color(x, y, act));
                drive_pix(x, y, act, got);
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL random_pix(%0d,%0d,act=%0d): got %h expected %h", x, y, act, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_cooldown();
        test_free_reuse();
        test_pool_full();
        test_low_ship_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
